// File: rtl/lock_counter.sv
// Settle counter for clk_lock_gen: counts post-reset edges and raises a sticky
// locked flag once the configured settling time has elapsed.
module lock_counter #(
    parameter int LOCK_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_locked
);

    localparam int LCNT_W = (LOCK_CYCLES > 0) ? $clog2(LOCK_CYCLES + 1) : 1;
    // Count value seen on the edge that completes settling; LOCK_CYCLES=0 locks on the first edge.
    localparam int LAST   = (LOCK_CYCLES > 0) ? LOCK_CYCLES - 1 : 0;

    logic [LCNT_W-1:0] r_cnt;
    logic              r_locked;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt    <= '0;
            r_locked <= 1'b0;
        end else if (!r_locked) begin
            r_cnt <= r_cnt + LCNT_W'(1);
            if (r_cnt == LCNT_W'(LAST))
                r_locked <= 1'b1;
        end
    end

    assign o_locked = r_locked;

endmodule

// File: rtl/clk_lock_gen.sv
// PLL stand-in: derives c0 at inclk0*CLK_MUL/(2*CLK_DIV) from a phase accumulator,
// with a rising-edge strobe and a settling-time lock flag. All outputs registered.
module clk_lock_gen #(
    parameter int INPUT_FREQUENCY = 50,
    parameter int CLK_MUL         = 1,
    parameter int CLK_DIV         = 1,
    parameter int LOCK_CYCLES     = 16
) (
    input  logic inclk0,
    input  logic areset,
    output logic c0,
    output logic c0_rise,
    output logic locked
);

    localparam int ACC_W = 16;

    generate
        if (CLK_MUL < 1 || CLK_DIV < 1 || CLK_MUL > CLK_DIV || CLK_DIV > 32767) begin : g_bad_params
            $fatal(1, "clk_lock_gen: illegal ratio %0d/%0d (input %0d MHz)",
                   CLK_MUL, CLK_DIV, INPUT_FREQUENCY);
        end
    endgenerate

    localparam logic [ACC_W:0] MUL_X = (ACC_W + 1)'(CLK_MUL);
    localparam logic [ACC_W:0] DIV_X = (ACC_W + 1)'(CLK_DIV);

    logic [ACC_W-1:0] r_acc;
    logic             r_c0;
    logic             r_rise;
    logic             w_locked;
    logic [ACC_W:0]   w_sum;
    logic [ACC_W:0]   w_diff;
    logic             w_wrap;
    logic [ACC_W-1:0] w_acc_nxt;

    lock_counter #(
        .LOCK_CYCLES(LOCK_CYCLES)
    ) u_lock (
        .i_clk   (inclk0),
        .i_rst   (areset),
        .o_locked(w_locked)
    );

    // acc < CLK_DIV <= 32767, so the 17-bit sum never overflows and the wrapped value fits 16 bits.
    assign w_sum     = {1'b0, r_acc} + MUL_X;
    assign w_diff    = w_sum - DIV_X;
    assign w_wrap    = (w_sum >= DIV_X);
    assign w_acc_nxt = w_wrap ? w_diff[ACC_W-1:0] : w_sum[ACC_W-1:0];

    always_ff @(posedge inclk0) begin
        if (areset || !w_locked) begin
            r_acc  <= '0;
            r_c0   <= 1'b0;
            r_rise <= 1'b0;
        end else begin
            r_acc  <= w_acc_nxt;
            r_rise <= w_wrap & ~r_c0;
            if (w_wrap)
                r_c0 <= ~r_c0;
        end
    end

    assign c0      = r_c0;
    assign c0_rise = r_rise;
    assign locked  = w_locked;

endmodule

// File: tb/tb_clk_lock_gen.sv
// Scoreboard bench for clk_lock_gen: directed per-edge expectations for several
// ratio/lock configurations, a mid-run reset, and a long-run average-rate check.
module tb_clk_lock_gen;

    logic       clk = 1'b0;
    logic [3:0] arst = 4'hF;
    logic [3:0] c0_w, rise_w, lock_w;

    always #5 clk = ~clk;

    clk_lock_gen #(.INPUT_FREQUENCY(50), .CLK_MUL(1), .CLK_DIV(1), .LOCK_CYCLES(16)) u_d0 (
        .inclk0(clk), .areset(arst[0]), .c0(c0_w[0]), .c0_rise(rise_w[0]), .locked(lock_w[0]));
    clk_lock_gen #(.INPUT_FREQUENCY(50), .CLK_MUL(1), .CLK_DIV(3), .LOCK_CYCLES(4)) u_d1 (
        .inclk0(clk), .areset(arst[1]), .c0(c0_w[1]), .c0_rise(rise_w[1]), .locked(lock_w[1]));
    clk_lock_gen #(.INPUT_FREQUENCY(50), .CLK_MUL(2), .CLK_DIV(5), .LOCK_CYCLES(0)) u_d2 (
        .inclk0(clk), .areset(arst[2]), .c0(c0_w[2]), .c0_rise(rise_w[2]), .locked(lock_w[2]));
    clk_lock_gen #(.INPUT_FREQUENCY(50), .CLK_MUL(3), .CLK_DIV(7), .LOCK_CYCLES(2)) u_d3 (
        .inclk0(clk), .areset(arst[3]), .c0(c0_w[3]), .c0_rise(rise_w[3]), .locked(lock_w[3]));

    typedef struct {
        int    d;
        logic  c0;
        logic  rise;
        logic  lk;
        string nm;
    } exp_t;

    exp_t q[$];
    exp_t m_e;
    int   n_vec  = 0;
    int   n_miss = 0;

    // Monitor: every edge with a pending expectation is compared just after the edge.
    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            m_e = q.pop_front();
            n_vec++;
            if (c0_w[m_e.d] !== m_e.c0 || rise_w[m_e.d] !== m_e.rise || lock_w[m_e.d] !== m_e.lk) begin
                n_miss++;
                $display("FAIL %s dut%0d @%0t: got c0=%b rise=%b locked=%b, want c0=%b rise=%b locked=%b",
                         m_e.nm, m_e.d, $time, c0_w[m_e.d], rise_w[m_e.d], lock_w[m_e.d],
                         m_e.c0, m_e.rise, m_e.lk);
            end
        end
    end

    // Drive one edge: set reset away from the active edge and queue the outputs expected after it.
    task automatic drv(input int d, input logic rst, input logic ec0, input logic er,
                       input logic el, input string nm);
        exp_t e;
        @(negedge clk);
        arst[d] = rst;
        e.d = d; e.c0 = ec0; e.rise = er; e.lk = el; e.nm = nm;
        q.push_back(e);
        @(posedge clk);
    endtask

    task automatic chk(input string nm, input int got, input int want);
        n_vec++;
        if (got != want) begin
            n_miss++;
            $display("FAIL %s: got %0d, want %0d", nm, got, want);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic c, r;
        int   k;
        int   rises, dbl, orphan;
        logic prev_rise;
        // Pattern of c0 for MUL=2/DIV=5 indexed by post-lock edge mod 10 (toggles at 3,5,8,10).
        logic [9:0] pat25;
        pat25 = 10'b1100011000;

        // Defaults: lock at edge 16, first rise at 17, then f/2.
        repeat (3) drv(0, 1'b1, 1'b0, 1'b0, 1'b0, "def_reset");
        for (int n = 1; n <= 30; n++) begin
            c = (n >= 17) && ((n - 17) % 2 == 0);
            drv(0, 1'b0, c, c, n >= 16, "def_run");
        end
        @(negedge clk) arst[0] = 1'b1;

        // MUL=1 DIV=3 LOCK=4: toggles at 7,10,13,...; then reset while c0=1 and relock.
        repeat (2) drv(1, 1'b1, 1'b0, 1'b0, 1'b0, "r13_reset");
        for (int n = 1; n <= 20; n++) begin
            c = (n >= 7) && (((n - 7) / 3) % 2 == 0);
            r = (n >= 7) && ((n - 7) % 6 == 0);
            drv(1, 1'b0, c, r, n >= 4, "r13_run");
        end
        drv(1, 1'b1, 1'b0, 1'b0, 1'b0, "mid_reset");
        for (int n = 1; n <= 16; n++) begin
            c = (n >= 7) && (((n - 7) / 3) % 2 == 0);
            r = (n >= 7) && ((n - 7) % 6 == 0);
            drv(1, 1'b0, c, r, n >= 4, "relock_run");
        end
        @(negedge clk) arst[1] = 1'b1;

        // MUL=2 DIV=5 LOCK=0: locked on first edge, two periods per 10 edges.
        repeat (2) drv(2, 1'b1, 1'b0, 1'b0, 1'b0, "r25_reset");
        for (int n = 1; n <= 21; n++) begin
            k = n - 1;
            c = pat25[k % 10];
            r = (k > 0) && (k % 5 == 3);
            drv(2, 1'b0, c, r, 1'b1, "r25_run");
        end
        @(negedge clk) arst[2] = 1'b1;

        // MUL=3 DIV=7 LOCK=2: lock timing via scoreboard, then 7000 post-lock edges.
        repeat (2) drv(3, 1'b1, 1'b0, 1'b0, 1'b0, "r37_reset");
        drv(3, 1'b0, 1'b0, 1'b0, 1'b0, "r37_lock1");
        drv(3, 1'b0, 1'b0, 1'b0, 1'b1, "r37_lock2");
        rises = 0; dbl = 0; orphan = 0; prev_rise = 1'b0;
        for (int i = 0; i < 7000; i++) begin
            @(posedge clk);
            #1;
            if (rise_w[3]) rises++;
            if (rise_w[3] && prev_rise) dbl++;
            if (rise_w[3] && !c0_w[3]) orphan++;
            prev_rise = rise_w[3];
        end
        chk("long_rise_count", rises, 1500);
        chk("long_back_to_back_rise", dbl, 0);
        chk("long_rise_without_c0", orphan, 0);
        chk("long_still_locked", int'(lock_w[3]), 1);

        repeat (2) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
